shift_ctrl_sequencer: RTL and testbench
=======================================

// Module: shift_ctrl_sequencer
// PURPOSE
//   Command-driven controller sitting directly upstream of the 4-bit rotate/shift register.
//   Accepts one command at a time (load, rotate right, rotate left, arithmetic shift right,
//   plus a step count) over a valid/ready handshake. Drives ParallelLoadn/RotateRight/
//   ASRight/Data_IN so the register performs exactly the requested number of steps at a
//   divided rate.
//   The register shifts on every clock unless loaded, so between steps this block holds it
//   by reloading its current value (Q_fb fed back from the register output).
// PARAMETERS
//   TICK_DIV  4  clocks per step tick; legal 1..15; 1 = one step every clock
// PORTS
//   clock          in   1  rising-edge clock, shared with the shift register
//   reset          in   1  synchronous, active-high; one clock; clears all state
//   cmd_valid      in   1  command present
//   cmd_ready      out  1  1 only in IDLE; command accepted on cmd_valid & cmd_ready
//   cmd_op         in   2  00 load, 01 rotate right, 10 rotate left, 11 arith shift right
//   cmd_data       in   4  value for load op (ignored otherwise)
//   cmd_count      in   4  steps for shift ops, 0..15 (ignored for load)
//   Q_fb           in   4  current register output Q
//   ParallelLoadn  out  1  to register; 0 = load Data_IN
//   RotateRight    out  1  to register
//   ASRight        out  1  to register
//   Data_IN        out  4  to register
//   busy           out  1  1 in LOAD, STEP, DONE
//   done           out  1  one-clock pulse in DONE state
// BEHAVIOUR
// - FSM states: IDLE, LOAD, STEP, DONE. Reset -> IDLE; divider = 0; remaining = 0; latched op = 00.
// - Outputs are combinational from state, latched op/data and Q_fb. No output registers.
// - HOLD drive: ParallelLoadn=0, Data_IN=Q_fb, RotateRight=0, ASRight=0.
// - IDLE:
//   - cmd_ready=1, busy=0, done=0; drive HOLD.
//   - On accept: latch op/data/count; clear divider.
//   - op 00 -> LOAD. op 01/10/11 with count>0 -> STEP. count==0 -> DONE.
// - LOAD: for 1 clock, ParallelLoadn=0 and Data_IN=latched data; then -> DONE.
// - STEP: divider counts 0..TICK_DIV-1 and wraps; tick = (divider==TICK_DIV-1).
//   - Non-tick cycle: drive HOLD.
//   - Tick cycle: ParallelLoadn=1 and remaining decrements.
//     - op 01: RotateRight=1, ASRight=0.
//     - op 10: RotateRight=0, ASRight=0.
//     - op 11: RotateRight=1, ASRight=1.
//     - When remaining reaches 0 on this tick -> DONE.
//   - First step occurs TICK_DIV clocks after accept; later steps are TICK_DIV clocks apart.
//   - Command completes with DONE TICK_DIV*count+1 clocks after accept.
// - DONE: done=1, busy=1, cmd_ready=0; drive HOLD; -> IDLE next clock.
//   - Back-to-back: a new command is accepted no earlier than 2 clocks after the done pulse
//     (DONE, then IDLE).
// - cmd_valid while busy is ignored, with no side effects. The bench keeps cmd_valid
//   asserted until cmd_ready.
// - Reset mid-command: -> IDLE at next edge; no done pulse; remaining steps discarded.
// - TICK_DIV=1: tick is constant 1 in STEP, so count steps occur on consecutive clocks.
// TESTING
// - Reset: assert reset 1 clk. State = IDLE, cmd_ready=1, busy=0, done=0, ParallelLoadn=0.
//   Data_IN tracks Q_fb (Q_fb=4'b1010 -> Data_IN=4'b1010).
// - Load: op=00, data=4'b1001. Next clock ParallelLoadn=0, Data_IN=1001; register Q=1001;
//   done pulses on the following clock.
// - Rotate right: Q=1001, op=01, count=2, TICK_DIV=4. Q holds 1001 for 3 clks, then 1100,
//   then 3 holds, then 0110; done at accept+9; Q stays 0110 afterward.
// - ASR / ROL: Q=1000, op=11, count=3 -> Q=1111. Q=1000, op=10, count=1 -> Q=0001.
// - Edges: count=0 -> done next clock, Q unchanged. cmd_valid held during STEP -> not
//   accepted until IDLE.
// - Reset mid-command: op=01, count=15; reset at accept+6 -> IDLE, no done pulse,
//   cmd_ready=1 the clock after.

Source files
------------

// File: rtl/shift_ctrl_sequencer.sv
// Command sequencer for the 4-bit rotate/shift register: runs one load or N shift
// steps per accepted command, holding the register by reloading Q_fb between steps.
module shift_ctrl_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_count,
  input  logic [3:0] Q_fb,
  output logic       ParallelLoadn,
  output logic       RotateRight,
  output logic       ASRight,
  output logic [3:0] Data_IN,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_div;
  logic [3:0] r_remaining;
  logic [3:0] r_data;
  logic [1:0] r_op;

  logic w_accept;
  logic w_tick;

  assign w_accept = cmd_valid && (r_state == IDLE);
  // With TICK_DIV=1 the divider stays at 0, so every STEP cycle is a tick.
  assign w_tick   = (r_state == STEP) && (r_div == 4'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_div       <= 4'd0;
      r_remaining <= 4'd0;
      r_op        <= 2'b00;
      r_data      <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op;
            r_data      <= cmd_data;
            r_remaining <= cmd_count;
            r_div       <= 4'd0;
            if (cmd_op == 2'b00)
              r_state <= LOAD;
            else if (cmd_count == 4'd0)
              r_state <= DONE;
            else
              r_state <= STEP;
          end
        end
        LOAD: r_state <= DONE;
        STEP: begin
          if (w_tick) begin
            r_div       <= 4'd0;
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1)
              r_state <= DONE;
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Default drive is HOLD: reload the register with its own output.
  always_comb begin
    cmd_ready     = (r_state == IDLE);
    busy          = (r_state != IDLE);
    done          = (r_state == DONE);
    ParallelLoadn = 1'b0;
    RotateRight   = 1'b0;
    ASRight       = 1'b0;
    Data_IN       = Q_fb;
    if (r_state == LOAD) begin
      Data_IN = r_data;
    end else if (w_tick) begin
      ParallelLoadn = 1'b1;
      RotateRight   = (r_op == 2'b01) || (r_op == 2'b11);
      ASRight       = (r_op == 2'b11);
    end
  end

endmodule

// File: tb/tb_shift_ctrl_sequencer.sv
// Bench for shift_ctrl_sequencer: models the downstream shift register, runs a vector
// table, hand-written corner sequences and random commands against an arithmetic model.
module tb_shift_ctrl_sequencer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic [3:0] q;
  logic       ParallelLoadn, RotateRight, ASRight;
  logic [3:0] Data_IN;
  logic       busy, done;
  logic       setQ;
  logic [3:0] setVal;

  logic       cmdValid1;
  logic [1:0] cmdOp1;
  logic [3:0] cmdData1, cmdCount1, q1, din1;
  logic       ready1, pl1, rr1, as1, busy1, done1;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  shift_ctrl_sequencer #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .Q_fb(q),
    .ParallelLoadn(ParallelLoadn), .RotateRight(RotateRight), .ASRight(ASRight),
    .Data_IN(Data_IN), .busy(busy), .done(done)
  );

  shift_ctrl_sequencer #(.TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmdValid1), .cmd_ready(ready1),
    .cmd_op(cmdOp1), .cmd_data(cmdData1), .cmd_count(cmdCount1), .Q_fb(q1),
    .ParallelLoadn(pl1), .RotateRight(rr1), .ASRight(as1),
    .Data_IN(din1), .busy(busy1), .done(done1)
  );

  // Downstream 4-bit rotate/shift register; setQ lets the bench preset it.
  always @(posedge clock) begin
    if (setQ)                         q <= setVal;
    else if (!ParallelLoadn)          q <= Data_IN;
    else if (RotateRight && ASRight)  q <= {q[3], q[3:1]};
    else if (RotateRight)             q <= {q[0], q[3:1]};
    else                              q <= {q[2:0], q[3]};
  end

  always @(posedge clock) begin
    if (!pl1)            q1 <= din1;
    else if (rr1 && as1) q1 <= {q1[3], q1[3:1]};
    else if (rr1)        q1 <= {q1[0], q1[3:1]};
    else                 q1 <= {q1[2:0], q1[3]};
  end

  function automatic logic [3:0] rotr(input logic [3:0] v, input int s);
    int n = s % 4;
    int x = int'(v);
    return 4'(((x >> n) | (x << (4 - n))) & 15);
  endfunction

  function automatic logic [3:0] asr(input logic [3:0] v, input int s);
    int x = v[3] ? int'(v) - 16 : int'(v);
    return 4'((x >>> s) & 15);
  endfunction

  // Register value seen j clocks after the accepting edge.
  function automatic logic [3:0] expectQ(input logic [1:0] op, input logic [3:0] data,
                                         input logic [3:0] q0, input int count,
                                         input int j, input int td);
    int steps;
    if (op == 2'b00) return (j >= 2) ? data : q0;
    steps = (j - 1) / td;
    if (steps > count) steps = count;
    case (op)
      2'b01:   return rotr(q0, steps);
      2'b10:   return rotr(q0, 4 - (steps % 4));
      default: return asr(q0, steps);
    endcase
  endfunction

  function automatic int expectLat(input logic [1:0] op, input int count, input int td);
    if (op == 2'b00) return 2;
    if (count == 0) return 1;
    return td * count + 1;
  endfunction

  task automatic checkOutput(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic presetQ(input logic [3:0] v);
    @(negedge clock);
    setQ = 1'b1;
    setVal = v;
    @(posedge clock);
    #1 setQ = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                               input logic [3:0] count, input logic [3:0] q0,
                               output int lat, output logic [3:0] fq);
    bit traceOk = 1'b1;
    bit busyOk = 1'b1;
    int expL = expectLat(op, int'(count), TD);
    logic [3:0] expF = expectQ(op, data, q0, int'(count), 1000, TD);
    presetQ(q0);
    @(negedge clock);
    checkOutput(cmd_ready === 1'b1, "readyBeforeCmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = count;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clock);
      if (q !== expectQ(op, data, q0, int'(count), j, TD)) traceOk = 1'b0;
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (busy !== 1'b1 || cmd_ready !== 1'b0) busyOk = 1'b0;
    end
    fq = q;
    checkOutput(lat == expL, "doneLatency", lat, expL);
    checkOutput(traceOk, "qTrace", int'(q), int'(expF));
    checkOutput(busyOk, "busyDuringCmd", int'(busy), 1);
    checkOutput(fq === expF, "finalQ", int'(fq), int'(expF));
    @(negedge clock);
    checkOutput(done === 1'b0 && cmd_ready === 1'b1 && q === expF, "idleAfterDone",
                int'({done, cmd_ready, q}), int'({1'b0, 1'b1, expF}));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] count;
    logic [3:0] q0;
    logic [3:0] expQ;
    int         expLat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int lat;
    int doneA, doneB;
    bit dropNext, doneSeen, qMoved;
    logic [3:0] fq, qAt9, qAt12;

    vecs[0] = '{2'b00, 4'b1001, 4'd0,  4'b1010, 4'b1001, 2};
    vecs[1] = '{2'b01, 4'b0000, 4'd2,  4'b1001, 4'b0110, 9};
    vecs[2] = '{2'b11, 4'b0000, 4'd3,  4'b1000, 4'b1111, 13};
    vecs[3] = '{2'b10, 4'b0000, 4'd1,  4'b1000, 4'b0001, 5};
    vecs[4] = '{2'b01, 4'b0000, 4'd0,  4'b0101, 4'b0101, 1};
    vecs[5] = '{2'b11, 4'b0000, 4'd15, 4'b0100, 4'b0000, 61};
    vecs[6] = '{2'b01, 4'b0000, 4'd4,  4'b1011, 4'b1011, 17};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0; cmd_count = 4'd0;
    cmdValid1 = 1'b0; cmdOp1 = 2'b00; cmdData1 = 4'd0; cmdCount1 = 4'd0;
    setQ = 1'b1; setVal = 4'b1010;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; setQ = 1'b0;

    @(negedge clock);
    checkOutput(cmd_ready === 1'b1 && busy === 1'b0 && done === 1'b0, "resetFlags",
                int'({cmd_ready, busy, done}), 4);
    checkOutput(ParallelLoadn === 1'b0, "resetHoldPL", int'(ParallelLoadn), 0);
    checkOutput(Data_IN === 4'b1010, "resetDataIN", int'(Data_IN), 10);
    presetQ(4'b0110);
    @(negedge clock);
    checkOutput(Data_IN === 4'b0110, "idleTracksQ", int'(Data_IN), 6);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].q0, lat, fq);
      checkOutput(lat == vecs[i].expLat, "vecLatency", lat, vecs[i].expLat);
      checkOutput(fq === vecs[i].expQ, "vecFinalQ", int'(fq), int'(vecs[i].expQ));
    end

    // cmd_valid held through a running command must wait for IDLE.
    presetQ(4'b1001);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd0; cmd_count = 4'd2;
    @(posedge clock);
    #1 cmd_op = 2'b00; cmd_data = 4'b0011;
    doneA = -1; doneB = -1; dropNext = 1'b0; qAt9 = 4'hx; qAt12 = 4'hx;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      if (dropNext) cmd_valid = 1'b0;
      if (cmd_ready === 1'b1 && cmd_valid) dropNext = 1'b1;
      if (j == 9) qAt9 = q;
      if (j == 12) qAt12 = q;
      if (done === 1'b1) begin
        if (doneA < 0) doneA = j;
        else if (doneB < 0) doneB = j;
      end
    end
    cmd_valid = 1'b0;
    checkOutput(doneA == 9, "heldFirstDone", doneA, 9);
    checkOutput(qAt9 === 4'b0110, "heldFirstQ", int'(qAt9), 6);
    checkOutput(doneB == 12, "heldSecondDone", doneB, 12);
    checkOutput(qAt12 === 4'b0011, "heldSecondQ", int'(qAt12), 3);

    // Reset in the middle of a long rotate.
    presetQ(4'b1001);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd15;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput(cmd_ready === 1'b1 && busy === 1'b0 && done === 1'b0, "midResetIdle",
                int'({cmd_ready, busy, done}), 4);
    checkOutput(q === 4'b1100, "midResetQ", int'(q), 12);
    doneSeen = 1'b0; qMoved = 1'b0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clock);
      if (done === 1'b1) doneSeen = 1'b1;
      if (q !== 4'b1100) qMoved = 1'b1;
    end
    checkOutput(!doneSeen, "midResetNoDone", int'(doneSeen), 0);
    checkOutput(!qMoved, "midResetQHeld", int'(q), 12);

    // TICK_DIV=1: steps on consecutive clocks.
    @(negedge clock);
    cmdValid1 = 1'b1; cmdOp1 = 2'b00; cmdData1 = 4'b0001;
    @(posedge clock);
    #1 cmdValid1 = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput(q1 === 4'b0001 && ready1 === 1'b1, "td1Load", int'(q1), 1);
    cmdValid1 = 1'b1; cmdOp1 = 2'b01; cmdCount1 = 4'd3;
    @(posedge clock);
    #1 cmdValid1 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clock);
      checkOutput(q1 === expectQ(2'b01, 4'd0, 4'b0001, 3, j, 1), "td1Trace", int'(q1),
                  int'(expectQ(2'b01, 4'd0, 4'b0001, 3, j, 1)));
      checkOutput(done1 === (j == 4), "td1Done", int'(done1), int'(j == 4));
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0] rOp = 2'($urandom_range(0, 3));
      logic [3:0] rData = 4'($urandom_range(0, 15));
      logic [3:0] rCount = 4'($urandom_range(0, 15));
      logic [3:0] rQ = 4'($urandom_range(0, 15));
      applyStimulus(rOp, rData, rCount, rQ, lat, fq);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
